vram_scan_arbiter: RTL
======================

Name: vram_scan_arbiter

Overview:
Sequences and shares the single-port framebuffer RAM between the VGA scanout path and a pixel writer (rasteriser/host). It generates raster-order read addresses for one frame per frame_start and keeps the downstream scanout FIFO topped up. Writes go in the gaps between reads. It sits between the framebuffer BRAM, the scanout FIFO feeding the vga timing/colour block, and the draw engine.

Parameters:
H_VIS_AREA_PXL, 800, visible pixels per line
V_VIS_AREA_PXL, 600, visible lines per frame
ADDR_BITS, 19, framebuffer address width (must hold H*V-1)
DATA_BITS, 12, pixel width (3 x 4-bit channels)
FIFO_DEPTH, 64, scanout FIFO capacity in pixels
LVL_BITS, 7, width of fifo_level (holds FIFO_DEPTH)
LOW_WATER, 16, reads become urgent below this fill
MAX_RD_RUN, 8, max consecutive reads while a write waits
MEM_LATENCY, 2, RAM read latency in cycles (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse: restart scanout at address 0
fifo_level  in  LVL_BITS  current scanout FIFO occupancy
wr_valid  in  1  writer request
wr_ready  out  1  write accepted this cycle (combinational)
wr_addr  in  ADDR_BITS  write address
wr_data  in  DATA_BITS  write pixel
mem_en  out  1  RAM access strobe (registered)
mem_we  out  1  1 = write, 0 = read (registered)
mem_addr  out  ADDR_BITS  RAM address (registered)
mem_wdata  out  DATA_BITS  RAM write data (registered)
mem_rdata  in  DATA_BITS  RAM read data
pix_valid  out  1  scanout pixel push to FIFO
pix_data  out  DATA_BITS  scanout pixel (= mem_rdata)
fetch_done  out  1  all H*V reads of current frame issued

Behaviour:
- Clock/reset: one clock, clk; reset synchronous, active-high.
- Reset: state IDLE, rd_addr=0, run counter=0, in-flight pipe cleared. Outputs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, pix_valid=0, fetch_done=0, wr_ready=0.
- States:
  - IDLE: no reads. frame_start -> FETCH.
  - FETCH: reads issued. Issuing address H*V-1 -> DONE.
  - DONE: fetch_done=1, writes only.
  - frame_start in any state: rd_addr=0 and state FETCH on the next cycle. No read is granted in the frame_start cycle. A write may still be granted in that cycle.
- inflight = read grants not yet returned, counted 0..MEM_LATENCY+1. It includes the registered issue stage.
- room = (fifo_level + inflight < FIFO_DEPTH). urgent = (fifo_level + inflight < LOW_WATER). Compute the sums at LVL_BITS+1 width with no wrap.
- Grant decision each cycle, in priority order:
  1. rd_ok = FETCH & room & !frame_start. If rd_ok & urgent: grant read.
  2. Else if wr_valid & (!rd_ok | run >= MAX_RD_RUN): grant write.
  3. Else if rd_ok: grant read.
  4. Else: idle.
- Run counter: increments on each read grant while wr_valid=1, saturating at MAX_RD_RUN. Clears on a write grant or when wr_valid=0. Urgent reads may exceed MAX_RD_RUN; writes can starve only while the FIFO is below LOW_WATER.
- wr_ready=1 exactly in cycles a write is granted. Transfer occurs on wr_valid & wr_ready.
- Issue timing: a grant in cycle t drives mem_* in cycle t+1 (mem_en=1). A read drives mem_addr=rd_addr, then rd_addr increments. At most one access per cycle.
- Read return: a read with mem_en in cycle u returns mem_rdata in u+MEM_LATENCY. pix_valid=1 in that cycle and pix_data=mem_rdata.
- Pixel ordering: strictly increasing address, one pix_valid per read.
- frame_start kills all in-flight reads: their pix_valid is suppressed and inflight drops to 0. The FIFO flush is external.
- fifo_level is trusted. The room rule guarantees no FIFO overflow even with zero drain.

Test Plan:
- Reset held 3 cycles, then released with no frame_start -> all outputs 0, no mem_en, state IDLE; writes accepted one per cycle with wr_ready=1.
- frame_start, fifo_level=0, no writes -> mem_en reads at addresses 0,1,2,... every cycle. pix_valid starts 1+MEM_LATENCY cycles after the grant cycle. Issue stops when fifo_level+inflight=64.
- fifo_level=40 (not urgent), wr_valid held high -> pattern of 8 reads then 1 write repeats; mem_we=1 carries wr_addr/wr_data.
- fifo_level=10 (urgent), wr_valid high -> reads every cycle, wr_ready=0 until level+inflight>=16.
- frame_start with 2 reads in flight at rd_addr=500 -> those two pix_valid are suppressed; next read address is 0.
- Small params (H=4, V=2), fifo_level=0 -> exactly 8 reads, addresses 0..7; fetch_done=1 the cycle after the grant of address 7; then no reads until the next frame_start.

Source files
------------

// File: rtl/vram_scan_arbiter_if.sv
// Write-request handshake and single-port framebuffer RAM bus shared by
// the pixel writer, vram_scan_arbiter and the framebuffer BRAM.

interface vram_wr_if #(
   parameter int ADDR_BITS = 19,
   parameter int DATA_BITS = 12
);
   logic                 wr_valid;
   logic                 wr_ready;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [DATA_BITS-1:0] wr_data;

   modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

interface vram_mem_if #(
   parameter int ADDR_BITS = 19,
   parameter int DATA_BITS = 12
);
   logic                 mem_en;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [DATA_BITS-1:0] mem_wdata;
   logic [DATA_BITS-1:0] mem_rdata;

   modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
   modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares the single-port framebuffer between raster-order scanout reads and
// writer requests, keeping the scanout FIFO topped up without overflowing it.

module vram_scan_arbiter #(
   parameter int H_VIS_AREA_PXL = 800,
   parameter int V_VIS_AREA_PXL = 600,
   parameter int ADDR_BITS      = 19,
   parameter int DATA_BITS      = 12,
   parameter int FIFO_DEPTH     = 64,
   parameter int LVL_BITS       = 7,
   parameter int LOW_WATER      = 16,
   parameter int MAX_RD_RUN     = 8,
   parameter int MEM_LATENCY    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_start_i,
   input  logic [LVL_BITS-1:0]  fifo_level_i,
   vram_wr_if.slave             wr,
   vram_mem_if.master           mem,
   output logic                 pix_valid_o,
   output logic [DATA_BITS-1:0] pix_data_o,
   output logic                 fetch_done_o
);

   localparam int SUM_BITS = LVL_BITS + 1;
   localparam int RUN_BITS = $clog2(MAX_RD_RUN + 1);

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(H_VIS_AREA_PXL * V_VIS_AREA_PXL - 1);
   localparam logic [SUM_BITS-1:0]  DEPTH_S   = SUM_BITS'(FIFO_DEPTH);
   localparam logic [SUM_BITS-1:0]  LOW_S     = SUM_BITS'(LOW_WATER);
   localparam logic [RUN_BITS-1:0]  RUN_MAX   = RUN_BITS'(MAX_RD_RUN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
   logic [RUN_BITS-1:0]    run_q, run_d;
   logic [MEM_LATENCY-1:0] ret_q, ret_d;
   logic                   mem_en_q, mem_en_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_BITS-1:0]   mem_wdata_q, mem_wdata_d;
   logic                   fetch_done_q, fetch_done_d;

   logic                   rd_issue;
   logic [SUM_BITS-1:0]    inflight;
   logic [SUM_BITS-1:0]    level_sum;
   logic                   room;
   logic                   urgent;
   logic                   rd_ok;
   logic                   gnt_rd;
   logic                   gnt_wr;

   // A read sitting in the issue register is already committed to the FIFO.
   assign rd_issue = mem_en_q & ~mem_we_q;

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      inflight = SUM_BITS'(rd_issue);
      for (int k = 0; k < MEM_LATENCY; k++) begin
         inflight = inflight + SUM_BITS'(ret_q[k]);
      end
   end

   assign level_sum = SUM_BITS'(fifo_level_i) + inflight;
   assign room      = (level_sum < DEPTH_S);
   assign urgent    = (level_sum < LOW_S);
   assign rd_ok     = (state_q == S_FETCH) && room && !frame_start_i;

   assign gnt_wr = !reset && wr.wr_valid && !(rd_ok && urgent) && (!rd_ok || (run_q >= RUN_MAX));
   assign gnt_rd = !reset && rd_ok && !gnt_wr;

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      if (frame_start_i) begin
         state_d   = S_FETCH;
         rd_addr_d = '0;
      end else if (gnt_rd) begin
         rd_addr_d = rd_addr_q + ADDR_BITS'(1);
         if (rd_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
         end
      end
   end

   always_comb begin
      run_d = run_q;
      if (!wr.wr_valid || gnt_wr) begin
         run_d = '0;
      end else if (gnt_rd && (run_q < RUN_MAX)) begin
         run_d = run_q + RUN_BITS'(1);
      end
   end

   // Return pipe: ret_q[k] marks a read that left the issue register k+1 cycles ago.
   always_comb begin
      ret_d = '0;
      if (!frame_start_i) begin
         ret_d[0] = rd_issue;
         for (int k = 1; k < MEM_LATENCY; k++) begin
            ret_d[k] = ret_q[k-1];
         end
      end
   end

   always_comb begin
      mem_en_d     = gnt_rd | gnt_wr;
      mem_we_d     = gnt_wr;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if (gnt_wr) begin
         mem_addr_d  = wr.wr_addr;
         mem_wdata_d = wr.wr_data;
      end else if (gnt_rd) begin
         mem_addr_d  = rd_addr_q;
      end
      fetch_done_d = (state_d == S_DONE);
   end

   // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rd_addr_q    <= '0;
         run_q        <= '0;
         ret_q        <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fetch_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_addr_q    <= rd_addr_d;
         run_q        <= run_d;
         ret_q        <= ret_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         fetch_done_q <= fetch_done_d;
      end
   end

   assign wr.wr_ready    = gnt_wr;
   assign mem.mem_en     = mem_en_q;
   assign mem.mem_we     = mem_we_q;
   assign mem.mem_addr   = mem_addr_q;
   assign mem.mem_wdata  = mem_wdata_q;
   assign pix_valid_o    = ret_q[MEM_LATENCY-1] & ~frame_start_i;
   assign pix_data_o     = mem.mem_rdata;
   assign fetch_done_o   = fetch_done_q;

endmodule
